// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract unit with a start/busy/done handshake.
// A single full-adder/full-subtractor cell with a registered carry/borrow
// processes one operand bit per enabled clock, LSB first.
//
// Optional feature: define SAT_EN for unsigned saturation at completion.
// An add that carries out writes all ones, and a sub that borrows out writes
// zero. RCO always reports the raw carry/borrow.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous reset, active-high, overrides everything
//   enb   - global enable; 0 freezes FSM, index, carry and operand/shift regs
//   start - request an operation; sampled only in IDLE with enb=1
//   modo  - 00 A+B, 01 A-B, 10 Q+B, 11 Q-B
//   A, B  - operands (A is ignored in modes 10/11)
//   Q     - registered result
//   RCO   - registered carry-out (add) or borrow-out (sub)
//   busy  - operation in progress
//   done  - one-cycle pulse when Q/RCO are updated
module serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             start,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   idx, idx_n;
    logic               cy, cy_n;
    logic [WIDTH-1:0]   x, x_n;
    logic [WIDTH-1:0]   y, y_n;
    logic               op, op_n;
    logic [WIDTH-1:0]   sreg, sreg_n;
    logic [WIDTH-1:0]   q_n;
    logic               rco_n, busy_n, done_n;

    logic               xb, yb, sum_bit, cout;
    logic [WIDTH-1:0]   res;

    // Shared full-adder/full-subtractor cell on the current bit.
    assign xb      = x[idx];
    assign yb      = y[idx];
    assign sum_bit = xb ^ yb ^ cy;
    assign cout    = op ? ((~xb & yb) | (~(xb ^ yb) & cy))
                        : ((xb & yb) | (xb & cy) | (yb & cy));
    // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign res     = {sum_bit, sreg[WIDTH-1:1]};

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            cy    <= 1'b0;
            x     <= '0;
            y     <= '0;
            op    <= 1'b0;
            sreg  <= '0;
            Q     <= '0;
            RCO   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cy    <= cy_n;
            x     <= x_n;
            y     <= y_n;
            op    <= op_n;
            sreg  <= sreg_n;
            Q     <= q_n;
            RCO   <= rco_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cy_n    = cy;
        x_n     = x;
        y_n     = y;
        op_n    = op;
        sreg_n  = sreg;
        q_n     = Q;
        rco_n   = RCO;
        busy_n  = busy;
        done_n  = 1'b0;

        if (enb) begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        // Accumulate modes take the current Q as first operand.
                        x_n     = modo[1] ? Q : A;
                        y_n     = B;
                        op_n    = modo[0];
                        cy_n    = 1'b0;
                        idx_n   = '0;
                        busy_n  = 1'b1;
                        state_n = RUN;
                    end
                end
                RUN: begin
                    cy_n   = cout;
                    sreg_n = res;
                    idx_n  = idx + CNT_W'(1);
                    if (idx == LAST_IDX) begin
                        q_n     = res;
`ifdef SAT_EN
                        if (cout) begin
                            q_n = op ? '0 : '1;
                        end
`endif
                        rco_n   = cout;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        idx_n   = '0;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed self-checking bench for serial_addsub_ctrl at WIDTH=4.
module tb_serial_addsub_ctrl;

`ifdef SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk, rst, enb, start;
    logic [1:0] modo;
    logic [3:0] A, B, Q;
    logic       RCO, busy, done;

    int vectors;
    int miscompares;

    serial_addsub_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .enb(enb), .start(start), .modo(modo),
        .A(A), .B(B), .Q(Q), .RCO(RCO), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operation and apply its acceptance edge.
    task automatic go(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b);
        modo  = m;
        A     = a;
        B     = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Edges until done is seen; -1 if it never comes.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (Q !== 4'd0)    begin miscompares++; $display("FAIL reset_q got %0d want 0", Q); end
        vectors++; if (RCO !== 1'b0)  begin miscompares++; $display("FAIL reset_rco got %b want 0", RCO); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    endtask

    task automatic test_add();
        int cyc;
        go(2'b00, 4'd9, 4'd8);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL add_busy got %b want 1", busy); end
        vectors++; if (Q !== 4'd0) begin miscompares++; $display("FAIL add_q_hold got %0d want 0", Q); end
        wait_done(cyc);
        vectors++; if (cyc != 4) begin miscompares++; $display("FAIL add_latency got %0d want 4", cyc); end
        vectors++; if (Q !== (SAT ? 4'd15 : 4'd1)) begin miscompares++; $display("FAIL add_q got %0d want %0d", Q, SAT ? 15 : 1); end
        vectors++; if (RCO !== 1'b1) begin miscompares++; $display("FAIL add_rco got %b want 1", RCO); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL add_busy_end got %b want 0", busy); end
        step();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL add_done_pulse got %b want 0", done); end
        vectors++; if (Q !== (SAT ? 4'd15 : 4'd1)) begin miscompares++; $display("FAIL add_q_held got %0d want %0d", Q, SAT ? 15 : 1); end
        // Wrap boundary: 15+1.
        go(2'b00, 4'd15, 4'd1);
        wait_done(cyc);
        vectors++; if (Q !== (SAT ? 4'd15 : 4'd0)) begin miscompares++; $display("FAIL add_wrap_q got %0d want %0d", Q, SAT ? 15 : 0); end
        vectors++; if (RCO !== 1'b1) begin miscompares++; $display("FAIL add_wrap_rco got %b want 1", RCO); end
        step();
    endtask

    task automatic test_sub();
        int cyc;
        go(2'b01, 4'd3, 4'd5);
        wait_done(cyc);
        vectors++; if (cyc != 4) begin miscompares++; $display("FAIL sub_latency got %0d want 4", cyc); end
        vectors++; if (Q !== (SAT ? 4'd0 : 4'd14)) begin miscompares++; $display("FAIL sub_neg_q got %0d want %0d", Q, SAT ? 0 : 14); end
        vectors++; if (RCO !== 1'b1) begin miscompares++; $display("FAIL sub_neg_rco got %b want 1", RCO); end
        step();
        go(2'b01, 4'd6, 4'd6);
        wait_done(cyc);
        vectors++; if (Q !== 4'd0) begin miscompares++; $display("FAIL sub_eq_q got %0d want 0", Q); end
        vectors++; if (RCO !== 1'b0) begin miscompares++; $display("FAIL sub_eq_rco got %b want 0", RCO); end
        step();
        go(2'b01, 4'd7, 4'd2);
        wait_done(cyc);
        vectors++; if (Q !== 4'd5) begin miscompares++; $display("FAIL sub_pos_q got %0d want 5", Q); end
        vectors++; if (RCO !== 1'b0) begin miscompares++; $display("FAIL sub_pos_rco got %b want 0", RCO); end
        step();
    endtask

    task automatic test_back_to_back();
        int cyc;
        // Q=5 from the previous op; A is garbage and must be ignored.
        go(2'b10, 4'd15, 4'd6);
        modo  = 2'b11;
        A     = 4'd0;
        B     = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(cyc);
        vectors++; if (cyc != 3) begin miscompares++; $display("FAIL acc1_latency got %0d want 3", cyc); end
        vectors++; if (Q !== 4'd11) begin miscompares++; $display("FAIL acc1_q got %0d want 11", Q); end
        vectors++; if (RCO !== 1'b0) begin miscompares++; $display("FAIL acc1_rco got %b want 0", RCO); end
        // Start on the done cycle uses the freshly written Q.
        go(2'b10, 4'd0, 4'd6);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL acc2_accept got %b want 1", busy); end
        wait_done(cyc);
        vectors++; if (cyc != 4) begin miscompares++; $display("FAIL acc2_latency got %0d want 4", cyc); end
        vectors++; if (Q !== (SAT ? 4'd15 : 4'd1)) begin miscompares++; $display("FAIL acc2_q got %0d want %0d", Q, SAT ? 15 : 1); end
        vectors++; if (RCO !== 1'b1) begin miscompares++; $display("FAIL acc2_rco got %b want 1", RCO); end
        step();
    endtask

    task automatic test_stall();
        int cyc;
        go(2'b00, 4'd2, 4'd3);
        step();
        step();
        enb  = 1'b0;
        modo = 2'b01;
        A    = 4'd15;
        B    = 4'd15;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL stall_hold cycle %0d got busy=%b done=%b want busy=1 done=0", i, busy, done); end
        end
        enb = 1'b1;
        wait_done(cyc);
        vectors++; if (cyc != 2) begin miscompares++; $display("FAIL stall_latency got %0d want 2", cyc); end
        vectors++; if (Q !== 4'd5) begin miscompares++; $display("FAIL stall_q got %0d want 5", Q); end
        vectors++; if (RCO !== 1'b0) begin miscompares++; $display("FAIL stall_rco got %b want 0", RCO); end
        step();
    endtask

    task automatic test_abort();
        int cyc;
        go(2'b00, 4'd9, 4'd8);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (Q !== 4'd0) begin miscompares++; $display("FAIL abort_q got %0d want 0", Q); end
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL abort_flags got busy=%b done=%b want 0 0", busy, done); end
        go(2'b00, 4'd2, 4'd3);
        wait_done(cyc);
        vectors++; if (cyc != 4) begin miscompares++; $display("FAIL abort_restart_latency got %0d want 4", cyc); end
        vectors++; if (Q !== 4'd5) begin miscompares++; $display("FAIL abort_restart_q got %0d want 5", Q); end
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        enb   = 1'b1;
        start = 1'b0;
        modo  = 2'b00;
        A     = 4'd0;
        B     = 4'd0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_stall();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
